// File: rtl/raw_video_pkg.sv
// Shared types for the raw video frame monitor: FSM states, Bayer colour codes
// and saturating counter helpers.
package raw_video_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

  // Used both for the colour of a bar and for the colour of a Bayer site.
  typedef enum logic [1:0] {
    CLR_R = 2'd0,
    CLR_G = 2'd1,
    CLR_B = 2'd2
  } bayer_color_t;

  // RGGB mosaic: even lines alternate R/G, odd lines alternate G/B.
  function automatic bayer_color_t site_color(input logic line_odd, input logic pix_odd);
    if (!line_odd) return pix_odd ? CLR_G : CLR_R;
    else           return pix_odd ? CLR_B : CLR_G;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/raw_bar_ref.sv
// Expected-pixel generator for the R/G/B colour-bar test pattern seen through
// an RGGB Bayer mosaic.
module raw_bar_ref
  import raw_video_pkg::*;
#(
  parameter int WORD_WIDTH = 10,
  parameter int BAR_WIDTH  = 160
) (
  input  logic [11:0]           pix_idx,
  input  logic                  line_odd,
  output logic [WORD_WIDTH-1:0] expected
);

  localparam int PERIOD = 3 * BAR_WIDTH;

  logic [11:0]  bar_pos;
  bayer_color_t bar;
  bayer_color_t site;

  always_comb begin
    bar_pos  = 12'(32'(pix_idx) % PERIOD);
    bar      = bayer_color_t'(2'(32'(bar_pos) / BAR_WIDTH));
    site     = site_color(line_odd, pix_idx[0]);
    expected = (site == bar) ? {WORD_WIDTH{1'b1}} : {WORD_WIDTH{1'b0}};
  end

endmodule

// File: rtl/raw_frame_monitor.sv
// Raw frame monitor: measures line/frame geometry of a registered fv/lv/data
// stream and counts pixels that deviate from the colour-bar reference.
module raw_frame_monitor
  import raw_video_pkg::*;
#(
  parameter int WORD_WIDTH = 10,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int BAR_WIDTH  = 160
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fv,
  input  logic                  lv,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  clear,
  output logic [11:0]           line_len,
  output logic [11:0]           line_num,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           pix_err_cnt,
  output logic                  err_h,
  output logic                  err_v,
  output logic                  err_lv,
  output logic                  frame_done
);

  mon_state_t            state_reg, state_next;
  logic                  fv_reg, lv_reg;
  logic [WORD_WIDTH-1:0] data_reg;
  logic                  in_valid_reg;
  logic                  line_active_reg;
  logic [11:0]           pix_cnt_reg;
  logic [11:0]           line_cnt_reg;
  logic [WORD_WIDTH-1:0] expected;

  logic frame_start, pix_valid, line_end, pix_mismatch, stray_lv, in_done;

  raw_bar_ref #(
    .WORD_WIDTH(WORD_WIDTH),
    .BAR_WIDTH (BAR_WIDTH)
  ) u_bar_ref (
    .pix_idx (pix_cnt_reg),
    .line_odd(line_cnt_reg[0]),
    .expected(expected)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // in_valid_reg keeps the reset value of fv_reg from looking like a real fv low.
      ST_SYNC:  if (in_valid_reg && !fv_reg) state_next = ST_IDLE;
      ST_IDLE:  if (fv_reg) state_next = ST_FRAME;
      ST_FRAME: if (!fv_reg) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_SYNC;
    else       state_reg <= state_next;
  end

  // A line also ends when fv drops while lv is still high.
  assign frame_start  = (state_reg == ST_IDLE) && fv_reg;
  assign pix_valid    = (state_reg == ST_FRAME) && fv_reg && lv_reg;
  assign line_end     = line_active_reg && !pix_valid;
  assign pix_mismatch = pix_valid && (data_reg != expected);
  assign stray_lv     = lv_reg && !fv_reg;
  assign in_done      = (state_reg == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fv_reg          <= 1'b0;
      lv_reg          <= 1'b0;
      data_reg        <= '0;
      in_valid_reg    <= 1'b0;
      line_active_reg <= 1'b0;
      pix_cnt_reg     <= '0;
      line_cnt_reg    <= '0;
      line_len        <= '0;
      line_num        <= '0;
      frame_cnt       <= '0;
      pix_err_cnt     <= '0;
      err_h           <= 1'b0;
      err_v           <= 1'b0;
      err_lv          <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      fv_reg       <= fv;
      lv_reg       <= lv;
      data_reg     <= data;
      in_valid_reg <= 1'b1;
      frame_done   <= in_done;

      if (frame_start) begin
        pix_cnt_reg     <= '0;
        line_cnt_reg    <= '0;
        line_active_reg <= 1'b0;
      end else if (pix_valid) begin
        pix_cnt_reg     <= sat_inc12(pix_cnt_reg);
        line_active_reg <= 1'b1;
      end else if (line_end) begin
        pix_cnt_reg     <= '0;
        line_cnt_reg    <= sat_inc12(line_cnt_reg);
        line_len        <= pix_cnt_reg;
        line_active_reg <= 1'b0;
      end

      if (in_done) line_num <= line_cnt_reg;

      // clear takes priority over any same-cycle increment or flag set.
      if (clear) begin
        frame_cnt   <= '0;
        pix_err_cnt <= '0;
        err_h       <= 1'b0;
        err_v       <= 1'b0;
        err_lv      <= 1'b0;
      end else begin
        if (in_done) frame_cnt <= sat_inc16(frame_cnt);
        if (pix_mismatch) pix_err_cnt <= sat_inc16(pix_err_cnt);
        if (line_end && (pix_cnt_reg != 12'(H_ACTIVE))) err_h <= 1'b1;
        if (in_done && (line_cnt_reg != 12'(V_ACTIVE))) err_v <= 1'b1;
        if (stray_lv) err_lv <= 1'b1;
      end
    end
  end

endmodule

// File: doc/raw_frame_monitor.md
RAW_FRAME_MONITOR -- requirements
Module: raw_frame_monitor

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 10: width of the raw pixel word.
REQ-002 SHALL have parameter H_ACTIVE, default 1920: expected pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 1080: expected lines per frame.
REQ-004 SHALL have parameter BAR_WIDTH, default 160: pixels per colour bar.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port fv, input, 1: frame valid from the upstream raw source.
REQ-008 SHALL have port lv, input, 1: line valid; data is valid when lv is high.
REQ-009 SHALL have port data, input, WORD_WIDTH: raw Bayer pixel.
REQ-010 SHALL have port clear, input, 1: synchronous clear of counters and sticky flags.
REQ-011 SHALL have port line_len, output, 12: pixel count of the last completed line.
REQ-012 SHALL have port line_num, output, 12: line count of the last completed frame.
REQ-013 SHALL have port frame_cnt, output, 16: number of completed frames.
REQ-014 SHALL have port pix_err_cnt, output, 16: number of pixel mismatches.
REQ-015 SHALL have port err_h, err_v, err_lv, output, 1 each: sticky line-length, line-count and lv-outside-fv errors.
REQ-016 SHALL have port frame_done, output, 1: single-cycle pulse when frame results are published.

Function
REQ-017 SHALL register fv, lv and data once on input; all detection SHALL use the registered copies.
REQ-018 SHALL implement the FSM SYNC -> IDLE -> FRAME -> DONE -> IDLE.
REQ-019 SYNC: SHALL wait for registered fv low, then go to IDLE, so a partial frame after reset is ignored.
REQ-020 IDLE: on the registered fv rising edge, SHALL clear the per-frame line counter and go to FRAME.
REQ-021 FRAME: on the registered fv falling edge, SHALL go to DONE.
REQ-022 DONE: SHALL last exactly one cycle and assert frame_done, so frame_done is high 2 cycles after the first clk edge that samples fv low.
REQ-023 During each line, SHALL keep pixel index P (0-based) incrementing while lv is high.
REQ-024 On the lv falling edge, SHALL load line_len with the line's pixel count, set err_h if that count is not H_ACTIVE, and increment line index L.
REQ-025 In DONE, SHALL load line_num with L, set err_v if L is not V_ACTIVE, and increment frame_cnt.
REQ-026 The expected pixel SHALL be derived as follows:
- bar = (P mod 3*BAR_WIDTH) / BAR_WIDTH, where 0=R, 1=G, 2=B;
- site: L even and P even = R; L even and P odd = G; L odd and P even = G; L odd and P odd = B;
- expected = all-ones if site equals bar, else all-zeros.
REQ-027 Every lv-high pixel in FRAME that differs from the expected value SHALL increment pix_err_cnt.
REQ-028 P, L, line_len and line_num SHALL saturate at 4095; frame_cnt and pix_err_cnt SHALL saturate at 65535.
REQ-029 lv high while fv is low (registered) SHALL set err_lv; such pixels SHALL not be checked.
REQ-030 clear SHALL zero frame_cnt, pix_err_cnt, err_h, err_v and err_lv; clear SHALL win over a same-cycle increment or set.
REQ-031 clear SHALL not affect the FSM, line_len or line_num.
REQ-032 An fv fall mid-line SHALL end the line as if lv had fallen, then enter DONE.

Reset
REQ-033 On rstn low, SHALL set all outputs to 0, all registers to 0 and the FSM to SYNC, asynchronously.
REQ-034 Reset asserted mid-frame SHALL discard that frame; after release, monitoring SHALL resume at the next full frame.

Structure
REQ-035 The FSM state enum and the bar and site encodings SHALL live in package raw_video_pkg.
REQ-036 The expected-pixel generator (P, L -> expected word) SHALL be sub-module raw_bar_ref.

Verification
REQ-037 Feed a clean 16x4 frame (H_ACTIVE=16, V_ACTIVE=4, BAR_WIDTH=4) -> frame_done pulses once, line_len=16, line_num=4, frame_cnt=1, pix_err_cnt=0, no errors.
REQ-038 Same frame with data at L=1, P=5 forced to all-ones -> pix_err_cnt=1, err_h=0, err_v=0.
REQ-039 Line 2 shortened to 15 pixels, and a frame with only 3 lines -> err_h=1, line_len=15; err_v=1, line_num=3.
REQ-040 Release reset mid-frame with fv high -> no frame_done for that frame; the next full frame gives frame_cnt=1.
REQ-041 Pulse lv for 3 cycles with fv low, then assert clear in the same cycle as a frame_done -> err_lv=1 before clear; after clear, frame_cnt=0 and err_lv=0.
